// File: rtl/data_mem_ctrl_pkg.sv
// Shared encodings for the MEM-stage data RAM controller: bus widths,
// memory op codes and controller state codes.
package data_mem_ctrl_pkg;

  localparam int DataBus     = 32;
  localparam int DataAddrBus = 32;
  localparam int MemOpBus    = 3;

  localparam logic [MemOpBus-1:0] MEM_OP_LB  = 3'd0;
  localparam logic [MemOpBus-1:0] MEM_OP_LBU = 3'd1;
  localparam logic [MemOpBus-1:0] MEM_OP_LH  = 3'd2;
  localparam logic [MemOpBus-1:0] MEM_OP_LHU = 3'd3;
  localparam logic [MemOpBus-1:0] MEM_OP_LW  = 3'd4;
  localparam logic [MemOpBus-1:0] MEM_OP_SB  = 3'd5;
  localparam logic [MemOpBus-1:0] MEM_OP_SH  = 3'd6;
  localparam logic [MemOpBus-1:0] MEM_OP_SW  = 3'd7;

  localparam logic [1:0] MEMCTRL_IDLE   = 2'd0;
  localparam logic [1:0] MEMCTRL_ACCESS = 2'd1;
  localparam logic [1:0] MEMCTRL_DONE   = 2'd2;

  function automatic logic is_store_op(input logic [MemOpBus-1:0] op);
    return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
  endfunction

endpackage

// File: rtl/data_mem_ctrl_lane_align.sv
// Combinational big-endian lane steering: byte enables, store replication,
// load extraction with sign/zero extension and the misalignment flag.
module mem_lane_align
  import data_mem_ctrl_pkg::*;
(
  input  logic [MemOpBus-1:0] op_i,
  input  logic [1:0]          off_i,
  input  logic [DataBus-1:0]  wdata_i,
  input  logic [DataBus-1:0]  rdata_i,
  output logic [3:0]          sel_o,
  output logic [DataBus-1:0]  wdata_o,
  output logic [DataBus-1:0]  rdata_o,
  output logic                misalign_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte offset 0 lives in the most significant lane.
  always_comb begin
    case (off_i)
      2'd0:    w_byte = rdata_i[31:24];
      2'd1:    w_byte = rdata_i[23:16];
      2'd2:    w_byte = rdata_i[15:8];
      default: w_byte = rdata_i[7:0];
    endcase
    w_half = off_i[1] ? rdata_i[15:0] : rdata_i[31:16];
  end

  always_comb begin
    sel_o      = 4'b0000;
    wdata_o    = '0;
    rdata_o    = '0;
    misalign_o = 1'b0;
    case (op_i)
      MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: begin
        sel_o   = 4'b1000 >> off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = (op_i == MEM_OP_LB) ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
      end
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: begin
        sel_o      = off_i[1] ? 4'b0011 : 4'b1100;
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = (op_i == MEM_OP_LH) ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
        misalign_o = off_i[0];
      end
      default: begin
        sel_o      = 4'b1111;
        wdata_o    = wdata_i;
        rdata_o    = rdata_i;
        misalign_o = (off_i != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage bus initiator for the data RAM: one access at a time with
// registered RAM port signals, programmable wait states and flush abort.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_i,
  input  logic [MemOpBus-1:0]    op_i,
  input  logic [DataAddrBus-1:0] addr_i,
  input  logic [DataBus-1:0]     wdata_i,
  input  logic                   flush_i,
  output logic [DataBus-1:0]     rdata_o,
  output logic                   done_o,
  output logic                   adel_o,
  output logic                   ades_o,
  output logic                   stall_o,
  output logic                   ram_ce_o,
  output logic                   ram_we_o,
  output logic [3:0]             ram_sel_o,
  output logic [DataAddrBus-1:0] ram_addr_o,
  output logic [DataBus-1:0]     ram_data_o,
  input  logic [DataBus-1:0]     ram_data_i
);

  logic [1:0]             r_state;
  logic [3:0]             r_cnt;
  logic                   r_ce;
  logic                   r_we;
  logic [3:0]             r_sel;
  logic [DataAddrBus-1:0] r_addr;
  logic [DataBus-1:0]     r_data;
  logic [DataBus-1:0]     r_rdata;
  logic                   r_done;
  logic                   r_adel;
  logic                   r_ades;

  logic [3:0]             w_sel;
  logic [DataBus-1:0]     w_wdata;
  logic [DataBus-1:0]     w_ext;
  logic                   w_misalign;
  logic                   w_store;

  assign w_store = is_store_op(op_i);

  mem_lane_align u_align (
    .op_i       (op_i),
    .off_i      (addr_i[1:0]),
    .wdata_i    (wdata_i),
    .rdata_i    (ram_data_i),
    .sel_o      (w_sel),
    .wdata_o    (w_wdata),
    .rdata_o    (w_ext),
    .misalign_o (w_misalign)
  );

  // Request fields are held stable until done, so lane logic is reused in ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= MEMCTRL_IDLE;
      r_cnt   <= 4'd0;
      r_ce    <= 1'b0;
      r_we    <= 1'b0;
      r_sel   <= 4'b0000;
      r_addr  <= '0;
      r_data  <= '0;
      r_rdata <= '0;
      r_done  <= 1'b0;
      r_adel  <= 1'b0;
      r_ades  <= 1'b0;
    end else if (flush_i) begin
      r_state <= MEMCTRL_IDLE;
      r_cnt   <= 4'd0;
      r_ce    <= 1'b0;
      r_we    <= 1'b0;
      r_sel   <= 4'b0000;
      r_addr  <= '0;
      r_data  <= '0;
      r_rdata <= '0;
      r_done  <= 1'b0;
      r_adel  <= 1'b0;
      r_ades  <= 1'b0;
    end else begin
      case (r_state)
        MEMCTRL_IDLE: begin
          if (req_i && w_misalign) begin
            r_state <= MEMCTRL_DONE;
            r_done  <= 1'b1;
            r_adel  <= ~w_store;
            r_ades  <= w_store;
            r_rdata <= '0;
          end else if (req_i) begin
            r_state <= MEMCTRL_ACCESS;
            r_cnt   <= 4'(WAIT_CYCLES);
            r_ce    <= 1'b1;
            r_we    <= w_store;
            r_sel   <= w_sel;
            r_addr  <= {addr_i[DataAddrBus-1:2], 2'b00};
            r_data  <= w_store ? w_wdata : '0;
          end
        end
        MEMCTRL_ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_state <= MEMCTRL_DONE;
            r_done  <= 1'b1;
            r_rdata <= w_store ? '0 : w_ext;
            r_ce    <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= 4'b0000;
            r_addr  <= '0;
            r_data  <= '0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        MEMCTRL_DONE: begin
          r_state <= MEMCTRL_IDLE;
          r_done  <= 1'b0;
          r_adel  <= 1'b0;
          r_ades  <= 1'b0;
          r_rdata <= '0;
        end
        default: r_state <= MEMCTRL_IDLE;
      endcase
    end
  end

  assign rdata_o    = r_rdata;
  assign done_o     = r_done;
  assign adel_o     = r_adel;
  assign ades_o     = r_ades;
  assign ram_ce_o   = r_ce;
  assign ram_we_o   = r_we;
  assign ram_sel_o  = r_sel;
  assign ram_addr_o = r_addr;
  assign ram_data_o = r_data;
  assign stall_o    = req_i & ~r_done & ~flush_i;

endmodule
